// File: rtl/mem_align_sequencer.sv
// mem_align_sequencer
//   Sequences each load/store from the memory stage into one or two
//   word-aligned data-memory accesses. Accesses that straddle a word
//   boundary are split; load bytes from both words are merged and
//   returned right-aligned and zero-extended. The pipeline is held with
//   stall from the accept cycle until the last access completes.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   halt                       blocks acceptance of a new request in IDLE
//   req_valid/is_load/is_store request strobe and kind (both set = load)
//   req_size, req_addr         0 byte, 1 half, 2/3 word; byte address
//   req_wdata                  right-aligned store data
//   mem_addr/ren/wen           word-aligned access and its strobes
//   mem_wstrb, mem_wdata       byte-lane enables and lane-aligned data
//   mem_rdata, mem_ready       read data and completion of current access
//   stall                      hold the pipeline
//   resp_valid, resp_data      one-cycle completion pulse, load result
//   fault                      crossing request rejected (no split allowed)

module mem_align_sequencer #(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_W           = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              fault
);

    typedef enum logic [1:0] {StIdle, StAcc1, StAcc2, StResp} state_e;

    function automatic logic [3:0] size_strb(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // True when off + nbytes > 4, i.e. the access spills into the next word.
    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
        logic [3:0] nb;
        case (sz)
            2'd0:    nb = 4'd1;
            2'd1:    nb = 4'd2;
            default: nb = 4'd4;
        endcase
        return ({2'b00, off} + nb) > 4'd4;
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              store_q, store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              fault_q, fault_d;

    logic              accept;
    logic [1:0]        cur_off;
    logic [4:0]        byte_shift;
    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] next_word;
    logic [63:0]       lane_data;
    logic [7:0]        lane_strb;
    logic [63:0]       merged_lo;
    logic [63:0]       merged_both;

    assign accept     = req_valid & ~halt & (req_is_load | req_is_store);
    assign cur_off    = addr_q[1:0];
    assign byte_shift = {cur_off, 3'b000};
    assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign next_word  = word_addr + ADDR_W'(4);  // wraps at the top of the space

    // Store data and strobes laid across two consecutive words.
    assign lane_data  = {32'h0, wdata_q & size_mask(size_q)} << byte_shift;
    assign lane_strb  = {4'h0, size_strb(size_q)} << cur_off;

    // Load merge: hi word is zero for a non-crossing access.
    assign merged_lo   = {32'h0, mem_rdata} >> byte_shift;
    assign merged_both = {mem_rdata, lo_q} >> byte_shift;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        lo_d        = lo_q;
        resp_data_d = resp_data_q;
        fault_d     = fault_q;

        mem_addr    = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_wstrb   = 4'h0;
        mem_wdata   = 32'h0;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        fault       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    stall   = 1'b1;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    store_d = ~req_is_load;
                    wdata_d = req_wdata;
                    fault_d = 1'b0;
                    if (!ALLOW_MISALIGNED && crosses(req_addr[1:0], req_size)) begin
                        fault_d     = 1'b1;
                        resp_data_d = 32'h0;
                        state_d     = StResp;
                    end else begin
                        state_d = StAcc1;
                    end
                end
            end
            StAcc1: begin
                stall    = 1'b1;
                mem_addr = word_addr;
                mem_ren  = ~store_q;
                mem_wen  = store_q;
                if (store_q) begin
                    mem_wstrb = lane_strb[3:0];
                    mem_wdata = lane_data[31:0];
                end
                if (mem_ready) begin
                    lo_d = mem_rdata;
                    if (crosses(cur_off, size_q)) begin
                        state_d = StAcc2;
                    end else begin
                        resp_data_d = store_q ? 32'h0 : merged_lo[31:0] & size_mask(size_q);
                        state_d     = StResp;
                    end
                end
            end
            StAcc2: begin
                stall    = 1'b1;
                mem_addr = next_word;
                mem_ren  = ~store_q;
                mem_wen  = store_q;
                if (store_q) begin
                    mem_wstrb = lane_strb[7:4];
                    mem_wdata = lane_data[63:32];
                end
                if (mem_ready) begin
                    resp_data_d = store_q ? 32'h0 : merged_both[31:0] & size_mask(size_q);
                    state_d     = StResp;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                fault      = fault_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= 2'd0;
            store_q     <= 1'b0;
            wdata_q     <= 32'h0;
            lo_q        <= 32'h0;
            resp_data_q <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            store_q     <= store_d;
            wdata_q     <= wdata_d;
            lo_q        <= lo_d;
            resp_data_q <= resp_data_d;
            fault_q     <= fault_d;
        end
    end

    assign resp_data = resp_data_q;

endmodule

// File: tb/tb_mem_align_sequencer.sv
// Bench for mem_align_sequencer: a split-capable instance driven by a
// latency-configurable memory responder, plus a no-split instance
// (ALLOW_MISALIGNED = 0) driven by hand. Expected results come from a
// byte-addressed reference memory.

module tb_mem_align_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        halt, req_valid, req_is_load, req_is_store;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_data;
    logic        mem_ren, mem_wen, mem_ready, stall, resp_valid, fault;
    logic [3:0]  mem_wstrb;

    logic        req_valid2, mem_ready2;
    logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, resp_data2;
    logic        mem_ren2, mem_wen2, stall2, resp_valid2, fault2;
    logic [3:0]  mem_wstrb2;

    int n_checks = 0;
    int n_fail   = 0;

    mem_align_sequencer #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .req_valid(req_valid),
        .req_is_load(req_is_load), .req_is_store(req_is_store), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr), .mem_ren(mem_ren),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_data(resp_data), .fault(fault)
    );

    mem_align_sequencer #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_nosplit (
        .clk(clk), .rst_n(rst_n), .halt(halt), .req_valid(req_valid2),
        .req_is_load(req_is_load), .req_is_store(req_is_store), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_addr(mem_addr2), .mem_ren(mem_ren2),
        .mem_wen(mem_wen2), .mem_wstrb(mem_wstrb2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .stall(stall2),
        .resp_valid(resp_valid2), .resp_data(resp_data2), .fault(fault2)
    );

    // Word memory seen by the DUT and an independent byte-level reference.
    logic [31:0] wmem [logic [31:0]];
    logic [7:0]  bmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] wmem_rd(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : init_word(a);
    endfunction

    function automatic logic [7:0] bmem_rd(input logic [31:0] b);
        logic [31:0] w;
        if (bmem.exists(b)) return bmem[b];
        w = init_word({b[31:2], 2'b00}) >> (8 * b[1:0]);
        return w[7:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < nb; i++) r = r | (32'(bmem_rd(a + 32'(i))) << (8 * i));
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
        for (int i = 0; i < nb; i++) bmem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        wmem[a] = w;
        for (int j = 0; j < 4; j++) bmem[a + 32'(j)] = w[8*j +: 8];
    endtask

    // Memory responder: completes each access after 'lat' wait cycles and logs it.
    int          lat;
    bit          unstable;
    logic [31:0] q_addr[$];
    logic        q_ren[$];
    logic        q_wen[$];
    logic [3:0]  q_strb[$];
    logic [31:0] q_wdata[$];

    initial begin
        int          cnt;
        logic [31:0] s_addr, s_wdata, w;
        logic [3:0]  s_strb;
        logic        s_ren, s_wen;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        cnt = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    cnt = 0;
                end
                if (mem_ren || mem_wen) begin
                    if (cnt == 0) begin
                        s_addr = mem_addr; s_ren = mem_ren; s_wen = mem_wen;
                        s_strb = mem_wstrb; s_wdata = mem_wdata;
                    end else if (s_addr !== mem_addr || s_ren !== mem_ren || s_wen !== mem_wen ||
                                 s_strb !== mem_wstrb || s_wdata !== mem_wdata) begin
                        unstable = 1'b1;
                    end
                    if (cnt >= lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = wmem_rd(mem_addr);
                        q_addr.push_back(mem_addr); q_ren.push_back(mem_ren);
                        q_wen.push_back(mem_wen); q_strb.push_back(mem_wstrb);
                        q_wdata.push_back(mem_wdata);
                        if (mem_wen) begin
                            w = wmem_rd(mem_addr);
                            for (int j = 0; j < 4; j++)
                                if (mem_wstrb[j]) w[8*j +: 8] = mem_wdata[8*j +: 8];
                            wmem[mem_addr] = w;
                        end
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Drive one request into the split-capable instance and wait for its response.
    task automatic do_req(input bit ld, input bit st, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int l, input bit toggle_halt,
                          output logic [31:0] rdata, output logic [31:0] held,
                          output int cycles, output int stall_cycles, output logic flt);
        bit got;
        lat = l; unstable = 1'b0;
        q_addr.delete(); q_ren.delete(); q_wen.delete(); q_strb.delete(); q_wdata.delete();
        rdata = 32'h0; held = 32'h0; flt = 1'b0; got = 1'b0;
        @(negedge clk);
        halt = 1'b0; req_valid = 1'b1; req_is_load = ld; req_is_store = st;
        req_size = sz; req_addr = a; req_wdata = wd;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL accept_stall addr=%h: got %b, expected 1", a, stall);
        end
        cycles = 1; stall_cycles = 1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            cycles++;
            if (resp_valid === 1'b1) begin
                got = 1'b1; rdata = resp_data; flt = fault;
                n_checks++;
                if (stall !== 1'b0) begin
                    n_fail++; $display("FAIL resp_stall addr=%h: got %b, expected 0", a, stall);
                end
            end else begin
                if (stall === 1'b1) stall_cycles++;
                if (toggle_halt) halt = ~halt;
            end
        end
        halt = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL resp_timeout addr=%h: no resp_valid within 64 cycles", a);
        end
        @(negedge clk);
        held = resp_data;
        n_checks++;
        if (resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL resp_pulse addr=%h: got %b, expected 0", a, resp_valid);
        end
    endtask

    task automatic test_reset();
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if ({mem_ren, mem_wen, mem_wstrb, stall, resp_valid, fault} !== 9'h0 ||
                mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_data !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs phase=%0d: ren=%b wen=%b strb=%h addr=%h wdata=%h",
                         p, mem_ren, mem_wen, mem_wstrb, mem_addr, mem_wdata);
                $display("FAIL reset_outputs phase=%0d: stall=%b rv=%b rd=%h flt=%b, expected 0",
                         p, stall, resp_valid, resp_data, fault);
            end
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_aligned_load();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        set_word(32'h100, 32'hDEAD_BEEF);
        do_req(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, 1'b0, rd, hd, cyc, stc, flt);
        n_checks++;
        if (rd !== 32'hDEAD_BEEF || hd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL aligned_data: got %h/%h, expected deadbeef", rd, hd);
        end
        n_checks++;
        if (cyc != 3 || stc != 2) begin
            n_fail++; $display("FAIL aligned_timing: cycles=%0d stall=%0d, expected 3/2", cyc, stc);
        end
        n_checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h100 || q_ren[0] !== 1'b1 || q_wen[0] !== 1'b0)
        begin
            n_fail++; $display("FAIL aligned_access: count=%0d, expected 1 read at 100",
                               q_addr.size());
        end
    endtask

    task automatic test_cross_half_load();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        set_word(32'h100, 32'hAABB_CCDD);
        set_word(32'h104, 32'h1122_3344);
        do_req(1'b1, 1'b0, 2'd1, 32'h103, 32'h0, 0, 1'b0, rd, hd, cyc, stc, flt);
        n_checks++;
        if (rd !== 32'h0000_44AA) begin
            n_fail++; $display("FAIL cross_half_data: got %h, expected 000044aa", rd);
        end
        n_checks++;
        if (q_addr.size() != 2 || q_addr[0] !== 32'h100 || q_addr[1] !== 32'h104 || cyc != 4) begin
            n_fail++; $display("FAIL cross_half_access: count=%0d cycles=%0d, expected 2/4",
                               q_addr.size(), cyc);
        end
    endtask

    task automatic test_cross_store();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        do_req(1'b0, 1'b1, 2'd2, 32'h201, 32'h1234_5678, 0, 1'b0, rd, hd, cyc, stc, flt);
        ref_store(32'h201, 4, 32'h1234_5678);
        n_checks++;
        if (q_addr.size() != 2) begin
            n_fail++; $display("FAIL cross_store_count: got %0d, expected 2", q_addr.size());
        end else begin
            n_checks++;
            if (q_addr[0] !== 32'h200 || q_strb[0] !== 4'hE || q_wdata[0] !== 32'h3456_7800 ||
                q_wen[0] !== 1'b1) begin
                n_fail++; $display("FAIL cross_store_acc1: addr=%h strb=%h wdata=%h, expected 200/e/34567800",
                                   q_addr[0], q_strb[0], q_wdata[0]);
            end
            n_checks++;
            if (q_addr[1] !== 32'h204 || q_strb[1] !== 4'h1 || q_wdata[1] !== 32'h0000_0012 ||
                q_wen[1] !== 1'b1) begin
                n_fail++; $display("FAIL cross_store_acc2: addr=%h strb=%h wdata=%h, expected 204/1/00000012",
                                   q_addr[1], q_strb[1], q_wdata[1]);
            end
        end
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL store_resp_data: got %h, expected 0", rd);
        end
    endtask

    task automatic test_delayed_byte_halt();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        set_word(32'h300, 32'h1122_3344);
        do_req(1'b1, 1'b0, 2'd0, 32'h302, 32'h0, 3, 1'b1, rd, hd, cyc, stc, flt);
        n_checks++;
        if (rd !== 32'h0000_0022 || q_addr.size() != 1) begin
            n_fail++; $display("FAIL delayed_byte_data: got %h count=%0d, expected 00000022/1",
                               rd, q_addr.size());
        end
        n_checks++;
        if (cyc != 6 || stc != 5 || unstable) begin
            n_fail++; $display("FAIL delayed_byte_stall: cycles=%0d stall=%0d unstable=%b, expected 6/5/0",
                               cyc, stc, unstable);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        set_word(32'hFFFF_FFFC, 32'h8877_6655);
        set_word(32'h0000_0000, 32'h4433_2211);
        do_req(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, 1'b0, rd, hd, cyc, stc, flt);
        n_checks++;
        if (q_addr.size() != 2 || q_addr[0] !== 32'hFFFF_FFFC || q_addr[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_access: count=%0d, expected fffffffc then 0", q_addr.size());
        end
        n_checks++;
        if (rd !== 32'h2211_8877 || flt !== 1'b0) begin
            n_fail++; $display("FAIL wrap_data: got %h fault=%b, expected 22118877/0", rd, flt);
        end
    endtask

    task automatic test_halt_and_ignore();
        @(negedge clk);
        halt = 1'b1; req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_size = 2'd2; req_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin halt = 1'b0; req_is_load = 1'b0; end
            #1;
            n_checks++;
            if (stall !== 1'b0 || mem_ren !== 1'b0) begin
                n_fail++; $display("FAIL halt_ignore step=%0d: stall=%b ren=%b, expected 0/0",
                                   i, stall, mem_ren);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_both_kinds();
        logic [31:0] rd, hd; int cyc, stc; logic flt;
        set_word(32'h108, 32'h0BAD_F00D);
        do_req(1'b1, 1'b1, 2'd1, 32'h10A, 32'hFFFF_FFFF, 0, 1'b0, rd, hd, cyc, stc, flt);
        n_checks++;
        if (rd !== 32'h0000_0BAD || q_addr.size() != 1 || q_ren[0] !== 1'b1 || q_wen[0] !== 1'b0)
        begin
            n_fail++; $display("FAIL both_kinds: got %h count=%0d, expected load 00000bad",
                               rd, q_addr.size());
        end
    endtask

    task automatic test_nosplit();
        @(negedge clk);
        req_valid2 = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
        req_size = 2'd1; req_addr = 32'h101;
        @(posedge clk); #1;
        req_valid2 = 1'b0; req_is_load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_ren2 !== 1'b1 || mem_addr2 !== 32'h100 || mem_wen2 !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_half_acc: ren=%b addr=%h, expected 1/100",
                               mem_ren2, mem_addr2);
        end
        mem_rdata2 = 32'h1122_3344; mem_ready2 = 1'b1;
        @(posedge clk); #1;
        mem_ready2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp_valid2 !== 1'b1 || fault2 !== 1'b0 || resp_data2 !== 32'h0000_2233) begin
            n_fail++; $display("FAIL nosplit_half_resp: rv=%b flt=%b data=%h, expected 1/0/00002233",
                               resp_valid2, fault2, resp_data2);
        end
        @(negedge clk);
        req_valid2 = 1'b1; req_is_load = 1'b1; req_size = 2'd2; req_addr = 32'hFFFF_FFFE;
        #1;
        n_checks++;
        if (stall2 !== 1'b1 || mem_ren2 !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_accept: stall=%b ren=%b, expected 1/0", stall2, mem_ren2);
        end
        @(posedge clk); #1;
        req_valid2 = 1'b0; req_is_load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp_valid2 !== 1'b1 || fault2 !== 1'b1 || resp_data2 !== 32'h0 || mem_ren2 !== 1'b0 ||
            stall2 !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_fault: rv=%b flt=%b data=%h ren=%b stall=%b, expected 1/1/0/0/0",
                               resp_valid2, fault2, resp_data2, mem_ren2, stall2);
        end
        @(negedge clk);
        n_checks++;
        if (fault2 !== 1'b0 || resp_valid2 !== 1'b0 || mem_ren2 !== 1'b0 || mem_wen2 !== 1'b0) begin
            n_fail++; $display("FAIL nosplit_fault_pulse: flt=%b rv=%b ren=%b, expected 0/0/0",
                               fault2, resp_valid2, mem_ren2);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, hd, a, wd, exp, w, ed, d; int cyc, stc, nb, n, l, kind; logic flt;
        logic [1:0] sz; logic [3:0] es; bit ld;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 2));
            sz   = 2'($urandom_range(0, 3));
            nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            a    = (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
                                                 : 32'h1000 + 32'(4 * $urandom_range(0, 7)))
                   + 32'($urandom_range(0, 3));
            wd   = $urandom;
            l    = int'($urandom_range(0, 2));
            ld   = (kind != 1);
            n    = (int'(a[1:0]) + nb > 4) ? 2 : 1;
            exp  = ld ? ref_load(a, nb) : 32'h0;
            do_req(ld, kind != 0, sz, a, wd, l, 1'b0, rd, hd, cyc, stc, flt);
            if (!ld) ref_store(a, nb, wd);
            n_checks++;
            if (rd !== exp || hd !== exp || flt !== 1'b0) begin
                n_fail++; $display("FAIL rand_resp t=%0d a=%h sz=%0d ld=%b: got %h/%h, expected %h",
                                   t, a, sz, ld, rd, hd, exp);
            end
            n_checks++;
            if (cyc != ((n == 2) ? 4 + 2 * l : 3 + l) || q_addr.size() != n || unstable) begin
                n_fail++; $display("FAIL rand_timing t=%0d a=%h: cycles=%0d count=%0d, expected %0d/%0d",
                                   t, a, cyc, q_addr.size(), (n == 2) ? 4 + 2 * l : 3 + l, n);
            end
            for (int k = 0; k < n && k < q_addr.size(); k++) begin
                w = {a[31:2], 2'b00} + 32'(4 * k);
                es = 4'h0; ed = 32'h0;
                for (int j = 0; j < 4; j++) begin
                    d = w + 32'(j) - a;
                    if (d < 32'(nb)) begin
                        es[j] = 1'b1;
                        ed[8*j +: 8] = wd[8*d +: 8];
                    end
                end
                n_checks++;
                if (q_addr[k] !== w || q_ren[k] !== ld || q_wen[k] !== !ld ||
                    (!ld && (q_strb[k] !== es || q_wdata[k] !== ed))) begin
                    n_fail++;
                    $display("FAIL rand_access t=%0d k=%0d: addr=%h strb=%h wdata=%h, expected %h/%h/%h",
                             t, k, q_addr[k], q_strb[k], q_wdata[k], w, es, ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, hd; int cyc, stc; logic flt; bit seen;
        set_word(32'h400, 32'hCAFE_F00D);
        do_req(1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 0, 1'b0, rd, hd, cyc, stc, flt);
        lat = 2; seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
        req_size = 2'd2; req_addr = 32'h501; req_wdata = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        req_valid = 1'b0; req_is_store = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_wen === 1'b1 && mem_addr === 32'h504) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL reset_mid_reach: ACC2 write to 504 not observed within 40 cycles");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_wen !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0 ||
            mem_wdata !== 32'h0 || resp_data !== 32'h0 || resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_outputs: wen=%b stall=%b addr=%h strb=%h rd=%h, expected 0",
                               mem_wen, stall, mem_addr, mem_wstrb, resp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_wen !== 1'b0 || mem_ren !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_idle: wen=%b ren=%b stall=%b, expected 0/0/0",
                               mem_wen, mem_ren, stall);
        end
        set_word(32'h600, 32'h0123_4567);
        do_req(1'b1, 1'b0, 2'd2, 32'h600, 32'h0, 0, 1'b0, rd, hd, cyc, stc, flt);
        n_checks++;
        if (rd !== 32'h0123_4567 || cyc != 3 || q_addr.size() != 1) begin
            n_fail++; $display("FAIL reset_mid_recover: got %h cycles=%0d, expected 01234567/3", rd, cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0;
        req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid2 = 1'b0; mem_ready2 = 1'b0; mem_rdata2 = 32'h0;
        lat = 0; unstable = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_aligned_load();
        test_cross_half_load();
        test_cross_store();
        test_delayed_byte_halt();
        test_wrap();
        test_halt_and_ignore();
        test_both_kinds();
        test_nosplit();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
